// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared constants and types for the NxM round-robin crossbar
package xbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int XBAR_AW = 32;
    localparam int XBAR_DW = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

endpackage

// File: rtl/xbar_rr_arbiter.sv
// rtl/xbar_rr_arbiter.sv - per-slave round-robin arbiter, grant held until ack
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int MW        = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 ack,
    output logic [MW-1:0]        gnt_idx,
    output logic                 gnt_vld
);

    arb_state_t             state_q, state_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic [MW-1:0]          own_q, own_d;
    logic [2*N_MASTERS-1:0] req_rot;
    logic [MW:0]            rr_sum;
    logic [MW-1:0]          rr_idx;
    logic                   rr_hit;

    function automatic logic [MW-1:0] inc_mod(input logic [MW-1:0] v);
        if (v == MW'(N_MASTERS - 1)) return '0;
        return v + 1'b1;
    endfunction

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        req_rot = {req, req} >> ptr_q;
        rr_hit  = 1'b0;
        rr_sum  = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_hit = 1'b1;
                rr_sum = {1'b0, ptr_q} + (MW+1)'(k);
            end
        end
        if (rr_sum >= (MW+1)'(N_MASTERS)) rr_sum = rr_sum - (MW+1)'(N_MASTERS);
        rr_idx = rr_sum[MW-1:0];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (rr_hit) begin
                    gnt_idx = rr_idx;
                    gnt_vld = 1'b1;
                    if (ack) begin
                        ptr_d = inc_mod(rr_idx);
                    end else begin
                        state_d = ARB_HOLD;
                        own_d   = rr_idx;
                    end
                end
            end
            ARB_HOLD: begin
                // Owner abandoning its request releases the slave without moving the pointer.
                if (!req[own_q]) begin
                    state_d = ARB_IDLE;
                end else begin
                    gnt_idx = own_q;
                    gnt_vld = 1'b1;
                    if (ack) begin
                        state_d = ARB_IDLE;
                        ptr_d   = inc_mod(own_q);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (!reset_n) begin
            gnt_idx = '0;
            gnt_vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

endmodule

// File: rtl/xbar_rr_nxm.sv
// rtl/xbar_rr_nxm.sv - parametrised N-master x M-slave crossbar with read return routing
module xbar_rr_nxm
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 4,
    parameter int AW        = XBAR_AW,
    parameter int DW        = XBAR_DW,
    parameter int SEL_LSB   = AW - $clog2(N_SLAVES)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS-1:0]    m_cmd,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    output logic [N_MASTERS-1:0]    m_ack,
    output logic [N_MASTERS*DW-1:0] m_rdata,
    output logic [N_MASTERS-1:0]    m_rvalid,
    output logic [N_SLAVES-1:0]     s_req,
    output logic [N_SLAVES*AW-1:0]  s_addr,
    output logic [N_SLAVES-1:0]     s_cmd,
    output logic [N_SLAVES*DW-1:0]  s_wdata,
    input  logic [N_SLAVES-1:0]     s_ack,
    input  logic [N_SLAVES*DW-1:0]  s_rdata
);

    localparam int MW = $clog2(N_MASTERS);
    localparam int SW = $clog2(N_SLAVES);

    logic [N_SLAVES-1:0][N_MASTERS-1:0] cand;
    logic [N_SLAVES-1:0][MW-1:0]        gnt_idx;
    logic [N_SLAVES-1:0]                gnt_vld;
    logic [N_MASTERS-1:0]               ret_v_q, ret_v_d;
    logic [N_MASTERS-1:0][SW-1:0]       ret_s_q, ret_s_d;

    always_comb begin
        cand = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (m_req[i] && (m_addr[i*AW+SEL_LSB +: SW] == SW'(j))) cand[j][i] = 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N_SLAVES; j++) begin : g_arb
        xbar_rr_arbiter #(
            .N_MASTERS (N_MASTERS),
            .MW        (MW)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (cand[j]),
            .ack     (s_ack[j]),
            .gnt_idx (gnt_idx[j]),
            .gnt_vld (gnt_vld[j])
        );
    end

    always_comb begin
        s_req   = gnt_vld;
        s_addr  = '0;
        s_cmd   = '0;
        s_wdata = '0;
        m_ack   = '0;
        ret_v_d = '0;
        ret_s_d = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (gnt_vld[j] && (gnt_idx[j] == MW'(i))) begin
                    s_addr[j*AW +: AW]  = m_addr[i*AW +: AW];
                    s_cmd[j]            = m_cmd[i];
                    s_wdata[j*DW +: DW] = m_wdata[i*DW +: DW];
                    if (s_ack[j]) begin
                        m_ack[i]   = 1'b1;
                        ret_v_d[i] = (m_cmd[i] == CMD_READ);
                        ret_s_d[i] = SW'(j);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_v_q <= '0;
            ret_s_q <= '0;
        end else begin
            ret_v_q <= ret_v_d;
            ret_s_q <= ret_s_d;
        end
    end

    // Slave read data lands one cycle after its ack; steer it to the master that was acked.
    always_comb begin
        m_rdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                if (ret_v_q[i] && (ret_s_q[i] == SW'(j))) m_rdata[i*DW +: DW] = s_rdata[j*DW +: DW];
            end
        end
    end

    assign m_rvalid = ret_v_q;

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// tb/tb_xbar_rr_nxm.sv - self-checking bench for xbar_rr_nxm with behavioural crossbar model
module tb_xbar_rr_nxm;
    import xbar_pkg::*;

    localparam int NM  = 4;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SEL = 30;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NM-1:0]   m_req, m_cmd, m_ack, m_rvalid;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata, m_rdata;
    logic [NS-1:0]   s_req, s_cmd, s_ack;
    logic [NS*AW-1:0] s_addr;
    logic [NS*DW-1:0] s_wdata, s_rdata;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: per-slave pointer/holder, per-master pending read return.
    int ptr[NS], own[NS], ptr_n[NS], own_n[NS];
    bit hold[NS], hold_n[NS];
    bit rv[NM], rv_n[NM];
    int rs[NM], rs_n[NM];

    logic [NS-1:0]    e_sreq, e_scmd;
    logic [NS*AW-1:0] e_saddr;
    logic [NS*DW-1:0] e_swdata;
    logic [NM-1:0]    e_mack, e_rvalid;
    logic [NM*DW-1:0] e_rdata;

    xbar_rr_nxm #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .AW        (AW),
        .DW        (DW),
        .SEL_LSB   (SEL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_cmd    (s_cmd),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic int slave_of(input int c);
        return int'((m_addr >> (c * AW + SEL)) & (NS - 1));
    endfunction

    task automatic model_eval();
        int g;
        e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swdata = '0;
        e_mack = '0; e_rvalid = '0; e_rdata = '0;
        for (int j = 0; j < NS; j++) begin
            ptr_n[j] = ptr[j]; hold_n[j] = hold[j]; own_n[j] = own[j];
        end
        for (int i = 0; i < NM; i++) begin
            rv_n[i] = 1'b0; rs_n[i] = 0;
        end
        if (!reset_n) begin
            for (int j = 0; j < NS; j++) begin
                ptr[j] = 0; hold[j] = 1'b0; ptr_n[j] = 0; hold_n[j] = 1'b0;
            end
            for (int i = 0; i < NM; i++) rv[i] = 1'b0;
            return;
        end
        for (int i = 0; i < NM; i++) begin
            if (rv[i]) begin
                e_rvalid[i] = 1'b1;
                e_rdata[i*DW +: DW] = s_rdata[rs[i]*DW +: DW];
            end
        end
        for (int j = 0; j < NS; j++) begin
            g = -1;
            if (hold[j]) begin
                if (m_req[own[j]]) g = own[j];
                else hold_n[j] = 1'b0;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    int c;
                    c = (ptr[j] + k) % NM;
                    if (g < 0 && m_req[c] && slave_of(c) == j) g = c;
                end
            end
            if (g >= 0) begin
                e_sreq[j] = 1'b1;
                e_saddr[j*AW +: AW] = m_addr[g*AW +: AW];
                e_scmd[j] = m_cmd[g];
                e_swdata[j*DW +: DW] = m_wdata[g*DW +: DW];
                if (s_ack[j]) begin
                    e_mack[g] = 1'b1;
                    hold_n[j] = 1'b0;
                    ptr_n[j] = (g + 1) % NM;
                    if (m_cmd[g] == CMD_READ) begin
                        rv_n[g] = 1'b1;
                        rs_n[g] = j;
                    end
                end else begin
                    hold_n[j] = 1'b1;
                    own_n[j] = g;
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int j = 0; j < NS; j++) begin
            ptr[j] = ptr_n[j]; hold[j] = hold_n[j]; own[j] = own_n[j];
        end
        for (int i = 0; i < NM; i++) begin
            rv[i] = rv_n[i]; rs[i] = rs_n[i];
        end
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = '0; s_rdata = '0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        chk("s_req", s_req, e_sreq);
        chk("s_addr", s_addr, e_saddr);
        chk("s_cmd", s_cmd, e_scmd);
        chk("s_wdata", s_wdata, e_swdata);
        chk("m_ack", m_ack, e_mack);
        chk("m_rvalid", m_rvalid, e_rvalid);
        chk("m_rdata", m_rdata, e_rdata);
    end

    initial begin
        for (int j = 0; j < NS; j++) begin
            ptr[j] = 0; own[j] = 0; hold[j] = 1'b0;
        end
        for (int i = 0; i < NM; i++) begin
            rv[i] = 1'b0; rs[i] = 0;
        end

        // Reset with every master requesting slave 0.
        reset_n = 1'b0;
        m_req = 4'b1111; m_cmd = {NM{CMD_WRITE}}; m_wdata = '0; s_rdata = '0;
        for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 32'h0000_1000 + i;
        s_ack = 4'b0001;
        #1;
        chk("rst_s_req", s_req, 4'b0000);
        chk("rst_m_ack", m_ack, 4'b0000);
        chk("rst_m_rvalid", m_rvalid, 4'b0000);
        cyc(); cyc();
        reset_n = 1'b1;
        #1;
        chk("rel_m_ack", m_ack, 4'b0001);
        chk("rel_s_req", s_req, 4'b0001);
        chk("rel_s_addr", s_addr[31:0], 32'h0000_1000);
        cyc();
        m_req = 4'b1110;
        #1;
        chk("rel_next_ack", m_ack, 4'b0010);
        cyc();

        // Single read M2 -> slave 1.
        do_reset();
        m_req = 4'b0100; m_cmd[2] = CMD_READ; m_addr[2*AW +: AW] = 32'h4000_0010; s_ack = 4'b0010;
        #1;
        chk("rd_s_req", s_req, 4'b0010);
        chk("rd_s_addr", s_addr[1*AW +: AW], 32'h4000_0010);
        chk("rd_m_ack", m_ack, 4'b0100);
        cyc();
        m_req = '0; s_ack = '0; s_rdata[1*DW +: DW] = 32'hCAFE_0001;
        #1;
        chk("rd_rvalid", m_rvalid, 4'b0100);
        chk("rd_rdata", m_rdata[2*DW +: DW], 32'hCAFE_0001);
        cyc();

        // Contention: all write slave 0, ack every cycle.
        do_reset();
        m_req = 4'b1111; m_cmd = {NM{CMD_WRITE}}; s_ack = 4'b0001;
        for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 32'h0000_0010 * i;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rot_m_ack", m_ack, 4'b0001 << (k % 4));
            cyc();
        end

        // Hold: M1 and M3 on slave 3, ack delayed 3 cycles.
        do_reset();
        m_req = 4'b1010; m_cmd = {NM{CMD_READ}};
        m_addr[1*AW +: AW] = 32'hC000_0011; m_addr[3*AW +: AW] = 32'hC000_0033;
        s_rdata[3*DW +: DW] = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_s_req", s_req, 4'b1000);
            chk("hold_s_addr", s_addr[3*AW +: AW], 32'hC000_0011);
            chk("hold_m_ack", m_ack, 4'b0000);
            cyc();
        end
        s_ack = 4'b1000;
        #1;
        chk("hold_ack_m1", m_ack, 4'b0010);
        cyc();
        m_req = 4'b1000;
        #1;
        chk("hold_ack_m3", m_ack, 4'b1000);
        chk("hold_s_addr_m3", s_addr[3*AW +: AW], 32'hC000_0033);
        chk("hold_rvalid_m1", m_rvalid, 4'b0010);
        chk("hold_rdata_m1", m_rdata[1*DW +: DW], 32'h1234_5678);
        cyc();
        m_req = '0; s_ack = '0;
        #1;
        chk("hold_rvalid_m3", m_rvalid, 4'b1000);
        cyc();

        // Parallel reads from two slaves.
        do_reset();
        m_req = 4'b0011; m_cmd = {NM{CMD_READ}};
        m_addr[0 +: AW] = 32'h0000_0040; m_addr[AW +: AW] = 32'h8000_0080; s_ack = 4'b0101;
        #1;
        chk("par_m_ack", m_ack, 4'b0011);
        cyc();
        m_req = '0; s_ack = '0;
        s_rdata[0 +: DW] = 32'hA5A5_A5A5; s_rdata[2*DW +: DW] = 32'h5A5A_5A5A;
        #1;
        chk("par_rvalid", m_rvalid, 4'b0011);
        chk("par_rdata0", m_rdata[0 +: DW], 32'hA5A5_A5A5);
        chk("par_rdata1", m_rdata[DW +: DW], 32'h5A5A_5A5A);
        cyc();

        // Reset while slave 2 is holding.
        do_reset();
        m_req = 4'b0001; m_cmd[0] = CMD_READ; m_addr[0 +: AW] = 32'h8000_0000; s_ack = '0;
        cyc(); cyc();
        reset_n = 1'b0; s_ack = 4'b0100;
        #1;
        chk("mid_rst_s_req", s_req, 4'b0000);
        chk("mid_rst_m_ack", m_ack, 4'b0000);
        cyc();
        reset_n = 1'b1; m_req = '0;
        #1;
        chk("post_rst_m_ack", m_ack, 4'b0000);
        chk("post_rst_rvalid", m_rvalid, 4'b0000);
        cyc();
        #1;
        chk("post_rst_rvalid2", m_rvalid, 4'b0000);
        m_req = 4'b0001;
        #1;
        chk("post_rst_new_ack", m_ack, 4'b0001);
        cyc();

        // Randomised traffic.
        m_req = '0; s_ack = '0;
        for (int n = 0; n < 3000; n++) begin
            bit drop;
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NM; i++) begin
                drop = 1'b0;
                if (!reset_n) begin
                    m_req[i] = 1'b0;
                    drop = 1'b1;
                end else if (m_req[i] && e_mack[i]) begin
                    m_req[i] = 1'b0;
                end else if (m_req[i] && $urandom_range(0, 63) == 0) begin
                    m_req[i] = 1'b0;
                    drop = 1'b1;
                end
                if (!m_req[i] && !drop && $urandom_range(0, 1) == 1) begin
                    m_req[i] = 1'b1;
                    m_addr[i*AW +: AW] = $urandom;
                    m_cmd[i] = 1'($urandom_range(0, 1));
                    m_wdata[i*DW +: DW] = $urandom;
                end
            end
            s_ack = 4'($urandom_range(0, 15));
            for (int j = 0; j < NS; j++) s_rdata[j*DW +: DW] = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xbar_rr_nxm.md
Name: xbar_rr_nxm

Overview:
- Parametrised N-master x M-slave crossbar on the team's req/addr/cmd/wdata/ack/rdata bus. Successor to the fixed 4x4 cross_bar.
- Slave is selected by the top address bits. Each slave has its own round-robin arbiter with grant hold until ack.
- Read data is routed back to the requesting master one cycle after ack, with a new per-master rvalid strobe.
- Sits between master agents and slave devices in the system and bench tops.

Parameters:
N_MASTERS, 4, number of master ports (2..8)
N_SLAVES, 4, number of slave ports (power of 2, 2..8)
AW, 32, address width
DW, 32, data width
SEL_LSB, AW-$clog2(N_SLAVES), LSB of the slave-select field in the address

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
m_req  in  N_MASTERS  master request, held until m_ack
m_addr  in  N_MASTERS*AW  master address, master i at [i*AW +: AW]
m_cmd  in  N_MASTERS  0=read, 1=write
m_wdata  in  N_MASTERS*DW  write data, valid with addr
m_ack  out  N_MASTERS  request accepted this cycle
m_rdata  out  N_MASTERS*DW  read data, cycle after read ack
m_rvalid  out  N_MASTERS  marks m_rdata valid
s_req  out  N_SLAVES  request to slave
s_addr  out  N_SLAVES*AW  forwarded address, unmodified
s_cmd  out  N_SLAVES  forwarded cmd
s_wdata  out  N_SLAVES*DW  forwarded write data
s_ack  in  N_SLAVES  slave accepts request
s_rdata  in  N_SLAVES*DW  slave read data, cycle after s_ack

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n=0:
  - every arbiter is IDLE with rr pointer 0;
  - every return register is empty;
  - s_req=0, m_ack=0, m_rvalid=0, m_rdata=0, s_addr/s_cmd/s_wdata=0.
- Decode: master i targets slave d(i) = m_addr_i[SEL_LSB +: $clog2(N_SLAVES)]. It is a candidate for slave j when m_req[i] && d(i)==j.
- Arbiter per slave j: states IDLE, HOLD. Registers are ptr_j (rr pointer) and own_j (owner).
  - IDLE: grant goes to the first candidate searching from ptr_j upward, wrapping modulo N_MASTERS. No candidates means s_req[j]=0.
  - IDLE, grant g and s_ack[j]=1: stay IDLE, ptr_j <= (g+1) mod N_MASTERS.
  - IDLE, grant g and s_ack[j]=0: go to HOLD, own_j <= g.
  - HOLD: the granted master is own_j regardless of other requests.
    - s_ack[j]=1: go to IDLE, ptr_j <= (own_j+1) mod N_MASTERS.
    - s_ack[j]=0: stay in HOLD.
  - If m_req[own_j] drops in HOLD (protocol violation): go to IDLE and drive s_req[j]=0 that cycle. ptr_j does not change.
- Forwarding is combinational from the granted master: s_req, s_addr, s_cmd, s_wdata. With no grant, s_addr/s_cmd/s_wdata=0.
- m_ack[i] = s_ack[j] && grant_j==i. The path is combinational with zero added latency. A master is granted by at most one slave per cycle.
- Read return, per master i:
  - When m_ack[i]=1 and m_cmd[i]=0, register ret_v[i]<=1 and ret_s[i]<=j. Otherwise ret_v[i]<=0.
  - Next cycle: m_rvalid[i]=ret_v[i] and m_rdata[i]=s_rdata[ret_s[i]]. When ret_v[i]=0, m_rdata[i]=0.
  - Writes never produce m_rvalid.
- Back-to-back: a master may issue its next request in the cycle its read data returns. Return and the new arbitration are independent.
- Simultaneous events:
  - Ack on one slave and a new request to another slave in the same cycle are independent.
  - Two slaves returning data to different masters in the same cycle are both delivered.
- Reset asserted mid-transaction: HOLD is abandoned and pending rvalid is dropped. No ack or rdata leaks after release.
- Fairness: under continuous contention on one slave with a 1-cycle ack, grants rotate and each master is served within N_MASTERS acks.

Decomposition:
- Package xbar_pkg holds:
  - CMD_READ=1'b0, CMD_WRITE=1'b1;
  - typedef enum {ARB_IDLE, ARB_HOLD} arb_state_t;
  - default AW/DW localparams.
- Sub-module xbar_rr_arbiter (N_MASTERS requests in, grant index plus grant valid out, s_ack in, holds state/ptr/own). Instantiated N_SLAVES times in a generate loop.
- Return routing and the muxes stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with m_req=4'b1111 -> s_req=0, m_ack=0, m_rvalid=0. After release, arbitration starts at master 0.
- Single read: M2 reads 32'h4000_0010 (slave 1), slave acks the same cycle with s_rdata=32'hCAFE_0001 next cycle -> s_req[1]=1 with s_addr unmodified, m_ack[2]=1, and next cycle m_rvalid[2]=1, m_rdata[2]=32'hCAFE_0001.
- Contention and rotation: all 4 masters write slave 0 continuously with ack every cycle -> grant order 0,1,2,3,0 and m_ack one-hot each cycle.
- Hold: M1 and M3 both request slave 3, slave delays ack 3 cycles -> s_req/s_addr stay on M1 throughout, then M3 is granted after M1's ack.
- Parallel: M0->slave 0 read and M1->slave 2 read acked in the same cycle with rdata A5A5A5A5 and 5A5A5A5A -> both m_rvalid the next cycle with correct, uncrossed data.
- Reset mid-HOLD: assert reset_n=0 while slave 2 is in HOLD -> s_req[2] drops immediately (async), and after release no m_ack or m_rvalid appears until a new request.
